mux_nway_pipe: RTL
==================

// Module: mux_nway_pipe
// PURPOSE
//  N-input, WIDTH-bit pipelined mux: binary select picks one of NUM_INPUTS operands,
//  result registered behind a 2-entry skid buffer with valid/ready on both sides.
//  Drop-in for pipeline-boundary operand selection (forwarding, writeback-source)
//  where the consuming stage can stall (ready low) or be flushed by hazard logic.
// PARAMETERS
//  WIDTH       32                    data bits per input and output
//  NUM_INPUTS  4                     operand count, >= 2
//  SEL_W       $clog2(NUM_INPUTS)    select width (derived; do not override)
// PORTS
//  clk__i        in   1             clock, rising edge
//  rst_n__i      in   1             synchronous reset, active low
//  data__i       in   NUM_INPUTS*W  packed operands; input k = data__i[k*WIDTH +: WIDTH]
//  select__i     in   SEL_W         operand index
//  valid__i      in   1             input beat present
//  ready__o      out  1             block accepts a beat this cycle
//  flush__i      in   1             discard all held beats
//  data__o       out  WIDTH         selected operand, registered
//  valid__o      out  1             data__o holds a beat
//  ready__i      in   1             downstream accepts data__o
//  sel_err__o    out  1             1-cycle pulse: accepted beat had select >= NUM_INPUTS
// BEHAVIOUR
//  - Accept = valid__i & ready__o; emit = valid__o & ready__i. Both on rising edge.
//  - Mux is combinational on accept; selected value is captured, never re-sampled.
//  - select__i >= NUM_INPUTS: beat accepted with data 0; sel_err__o = 1 next cycle.
//  - Latency: accepted beat appears on data__o/valid__o the next cycle if buffer was EMPTY.
//  - States (enum): EMPTY (no beat), ONE (main reg valid), TWO (main + skid valid).
//    EMPTY: accept -> ONE.
//    ONE: accept & !emit -> TWO (beat into skid); emit & !accept -> EMPTY;
//         accept & emit -> ONE (new beat into main); neither -> ONE.
//    TWO: emit -> ONE (skid moves to main); no accept possible.
//  - ready__o registered: 1 in EMPTY/ONE, 0 in TWO; never depends combinationally on ready__i.
//  - Order preserved: skid beat always emitted before any later beat.
//  - data__o/valid__o stable while valid__o & !ready__i (no change without emit).
//  - flush__i: next state EMPTY, valid__o = 0, ready__o = 1; beat offered in flush cycle
//    dropped (no sel_err__o for it); emit in flush cycle still counts downstream.
//  - Reset (rst_n__i low at edge): state EMPTY, data__o = 0, valid__o = 0, ready__o = 0,
//    sel_err__o = 0, skid data = 0. ready__o rises to 1 the first edge with rst_n__i high.
//    Reset mid-transfer discards held beats; reset wins over flush.
//  - Data regs load only on capture (no toggle when idle).
// STRUCTURE
//  - Package mux_pkg: typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
//    function automatic mux_sel(data, sel) returning WIDTH bits, 0 when out of range.
//  - Sub-module pipe_skid_buf #(WIDTH+1): generic 2-entry skid buffer (payload = data +
//    sel_err bit); top level = select decode + range check + pipe_skid_buf instance.
// TESTING
//  - Reset: hold rst_n__i low 3 cycles -> valid__o=0, data__o=0, ready__o=0; 1 cycle after
//    release ready__o=1.
//  - Streaming, WIDTH=32 N=4, ready__i=1: inputs {A,B,C,D}=0x11..,0x22..,0x33..,0x44..,
//    select 0,1,2,3 back-to-back -> data__o 0x11..,0x22..,0x33..,0x44.. on cycles 1-4, valid__o=1.
//  - Backpressure: ready__i=0, send 2 beats (sel 2 then 3) -> ready__o=0 after 2nd accept;
//    data__o holds C; raise ready__i -> C then D emitted in order, ready__o back to 1.
//  - Bad select, N=3 SEL_W=2: select=3, valid__i=1 -> data__o=0, valid__o=1, sel_err__o
//    pulses exactly 1 cycle.
//  - Flush in TWO state with valid__i=1 -> next cycle valid__o=0, ready__o=1, offered beat
//    never appears on data__o.
//  - Reset mid-transfer in TWO state -> both beats discarded, outputs at reset values.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and the operand-select helper for the pipelined N-way mux.
package mux_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

  // Upper bounds for the select helper; instances must stay within them.
  localparam int MUX_MAX_W  = 64;
  localparam int MUX_MAX_N  = 16;
  localparam int MUX_MAX_SW = 4;

  // Returns operand 'sel', or zero when sel is not below the live operand count.
  function automatic logic [MUX_MAX_W-1:0] mux_sel(
    input logic [MUX_MAX_N-1:0][MUX_MAX_W-1:0] data,
    input logic [MUX_MAX_SW-1:0]               sel,
    input logic [MUX_MAX_SW:0]                 num
  );
    if ({1'b0, sel} < num) return data[sel];
    return '0;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: registered ready, order-preserving, flushable.
module pipe_skid_buf
  import mux_pkg::*;
#(
  parameter int W = 33
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_flush,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  skid_state_t  r_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_valid;
  logic         r_ready;
  logic         w_acc;
  logic         w_emit;

  assign w_acc  = i_valid & r_ready;
  assign w_emit = r_valid & i_ready;

  // r_main always drives the output; r_skid only parks the beat that
  // arrived while the output was stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else if (i_flush) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          r_ready <= 1'b1;
          if (w_acc) begin
            r_main  <= i_data;
            r_valid <= 1'b1;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_acc && !w_emit) begin
            r_skid  <= i_data;
            r_ready <= 1'b0;
            r_state <= TWO;
          end else if (w_emit && !w_acc) begin
            r_valid <= 1'b0;
            r_state <= EMPTY;
          end else if (w_acc) begin
            r_main  <= i_data;
          end
        end
        TWO: begin
          if (w_emit) begin
            r_main  <= r_skid;
            r_ready <= 1'b1;
            r_state <= ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= EMPTY;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_main;

endmodule

// File: rtl/mux_nway_pipe.sv
// N-way operand select with range check, registered behind a 2-entry skid buffer.
module mux_nway_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
)(
  input  logic                        clk__i,
  input  logic                        rst_n__i,
  input  logic [NUM_INPUTS*WIDTH-1:0] data__i,
  input  logic [SEL_W-1:0]            select__i,
  input  logic                        valid__i,
  output logic                        ready__o,
  input  logic                        flush__i,
  output logic [WIDTH-1:0]            data__o,
  output logic                        valid__o,
  input  logic                        ready__i,
  output logic                        sel_err__o
);

  localparam logic [MUX_MAX_SW:0] NUM_L = NUM_INPUTS[MUX_MAX_SW:0];

  logic [MUX_MAX_N-1:0][MUX_MAX_W-1:0] w_ops;
  logic [MUX_MAX_SW-1:0]               w_sel;
  logic [WIDTH-1:0]                    w_mux;
  logic                                w_bad;
  logic                                w_acc;
  logic [WIDTH:0]                      w_buf_dout;
  logic                                w_unused_err;
  logic                                r_sel_err;

  for (genvar k = 0; k < MUX_MAX_N; k++) begin : g_ops
    if (k < NUM_INPUTS) begin : g_live
      assign w_ops[k] = MUX_MAX_W'(data__i[k*WIDTH +: WIDTH]);
    end else begin : g_pad
      assign w_ops[k] = '0;
    end
  end

  // A power-of-two operand count leaves no out-of-range select codes.
  if ((1 << SEL_W) == NUM_INPUTS) begin : g_full_range
    assign w_bad = 1'b0;
  end else begin : g_part_range
    assign w_bad = (select__i >= NUM_INPUTS[SEL_W-1:0]);
  end

  assign w_sel = MUX_MAX_SW'(select__i);
  assign w_mux = WIDTH'(mux_sel(w_ops, w_sel, NUM_L));
  assign w_acc = valid__i & ready__o;

  // Error bit travels with its beat so the payload is self-describing.
  pipe_skid_buf #(
    .W (WIDTH + 1)
  ) u_skid (
    .i_clk   (clk__i),
    .i_rst_n (rst_n__i),
    .i_data  ({w_bad, w_mux}),
    .i_valid (valid__i),
    .o_ready (ready__o),
    .i_flush (flush__i),
    .o_data  (w_buf_dout),
    .o_valid (valid__o),
    .i_ready (ready__i)
  );

  // Pulse tracks acceptance, not emission, so it fires even if the beat parks.
  always_ff @(posedge clk__i) begin
    if (!rst_n__i) r_sel_err <= 1'b0;
    else           r_sel_err <= w_acc & w_bad & ~flush__i;
  end

  assign data__o      = w_buf_dout[WIDTH-1:0];
  assign w_unused_err = w_buf_dout[WIDTH];
  assign sel_err__o   = r_sel_err;

endmodule
